if_fetch_buffer: RTL and testbench
==================================

Name: if_fetch_buffer

Overview:
- Consumer end of the program-counter interface. Takes the current PC, issues reads to the synchronous instruction memory, and pairs each returned word with its PC.
- Queues the pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Back-pressures the PC register through pc_stall whenever no FIFO slot can be guaranteed.
- Discards all queued and in-flight fetches on a redirect (branch/jump).

Parameters:
- WIDTH, 32, width of PC, memory address and instruction word.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0, value that the companion PC register loads on reset. Informational only; no logic in this block uses it.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- pc  in  WIDTH  current PC from the PC register.
- pc_stall  out  1  1 = PC register must hold pc this cycle.
- redirect  in  1  flush request; the PC register loads the new target in the same cycle.
- imem_rd_en  out  1  instruction-memory read strobe.
- imem_addr  out  WIDTH  read address; equals pc.
- imem_rdata  in  WIDTH  read data, valid exactly 1 cycle after imem_rd_en.
- instr_valid  out  1  FIFO head valid.
- instr  out  WIDTH  head instruction.
- instr_pc  out  WIDTH  PC of head instruction.
- instr_ready  in  1  decode accepts head.

Behaviour:
- Reset, checked on posedge when rst=1:
  - count=0, rd_ptr=wr_ptr=0, inflight_q=0, kill_q=0.
  - Outputs: instr_valid=0, instr=0, instr_pc=0, imem_rd_en=0, pc_stall=1.
  - Reset mid-operation drops all entries and in-flight reads.
- Issue rule (combinational):
  - issue = !rst && !redirect && (count + inflight_q < DEPTH).
  - imem_rd_en = issue; imem_addr = pc; pc_stall = !issue.
  - The count compares against the registered count, not the post-pop count. This is deliberately conservative: no pop-to-issue bypass.
- In-flight tracking:
  - inflight_q <= issue; pc_q <= pc when issue.
  - kill_q <= redirect && inflight_q. This also covers a redirect in the same cycle the response returns: that response is dropped.
- Response push:
  - push = inflight_q && !kill_q && !redirect.
  - On push, write {pc_q, imem_rdata} at wr_ptr; wr_ptr wraps modulo DEPTH.
  - Latency: pc sampled in cycle N lands in the FIFO at the end of N+1 and is visible at the head in cycle N+2 at the earliest.
- Pop:
  - pop = instr_valid && instr_ready && !redirect; rd_ptr wraps modulo DEPTH.
  - instr_valid = (count != 0).
  - instr and instr_pc are driven from the head entry; they must hold stable while instr_valid && !instr_ready.
- Count update:
  - count <= count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - Overflow is impossible by the credit rule. Assert count <= DEPTH and never (push && count==DEPTH && !pop).
- Redirect, single cycle:
  - Clears count and pointers to 0 and clears instr_valid on the next cycle.
  - No issue and no push in the redirect cycle. An in-flight response arriving in the redirect cycle or the cycle after is discarded.
  - The first fetch of the new target issues the cycle after redirect.
- Back-to-back redirects: each one blocks issue that cycle; the state stays empty.
- Throughput: with instr_ready=1 continuously, one instruction per cycle in steady state, because count + inflight stays ≤ 2 < DEPTH.
- The block does not check PC alignment; imem_addr is passed through unmodified.

Decomposition:
- Shared package if_pkg:
  - typedef fetch_entry_t = struct {pc, instr}.
  - localparam PTR_W = $clog2(DEPTH).
- One sub-module, sync_fifo: generic DEPTH×entry FIFO with push/pop/flush, count, and head outputs.
- if_fetch_buffer holds the issue/credit logic, in-flight/kill tracking, and the handshake glue.

Test Plan:
- Reset then release; imem returns pc+0x100 as data; instr_ready=1.
  - Required: cycle 0 issues pc=0.
  - instr_valid first rises in cycle 2 with instr_pc=0, instr=0x100.
  - Thereafter one instruction per cycle: pc 4, 8, …
- Hold instr_ready=0 from the start.
  - Required: exactly 4 issues (pc 0, 4, 8, C), then pc_stall=1 and imem_rd_en=0.
  - count=4, head stays instr_pc=0.
  - Raising instr_ready produces pops of 0, 4, 8, C in order, and issue resumes.
- Full FIFO, then instr_ready=1 for one cycle.
  - Required: the pop cycle still shows pc_stall=1.
  - Issue occurs the following cycle; no overflow assertion fires.
- Assert redirect in the cycle after issuing pc=0x20, with target 0x80.
  - Required: the 0x20 response is dropped and the FIFO is empty the next cycle.
  - The first valid instr_pc is 0x80.
- Assert rst for one cycle while count=3 and a read is in flight.
  - Required: instr_valid=0 and count=0 the next cycle.
  - The stale response never appears at the output.
- Wrap-around: stream 20 instructions with instr_ready toggling 1,0,1,0.
  - Required: output PCs are strictly sequential 0, 4, …, 0x4C with no loss or duplication.
  - instr/instr_pc stay stable while stalled.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch buffer.
package if_pkg;
  localparam int IF_WIDTH = 32;
  localparam int IF_DEPTH = 4;
  localparam int PTR_W    = $clog2(IF_DEPTH);

  typedef struct packed {
    logic [IF_WIDTH-1:0] pc;
    logic [IF_WIDTH-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_buffer_sync_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally.
module sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [W-1:0]               head_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale words are hidden by the count.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch buffer: issues imem reads from the PC under a credit rule, pairs each
// returned word with its PC, and hands the pairs to decode via valid/ready.
module if_fetch_buffer
  import if_pkg::*;
#(
  parameter int               WIDTH    = IF_WIDTH,
  parameter int               DEPTH    = IF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_stall,
  input  logic             redirect,
  output logic             imem_rd_en,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 2 * WIDTH;

  // Handshake: decode takes the head on any cycle where instr_valid and
  // instr_ready are both high and redirect is low; while instr_valid is high
  // and instr_ready is low the head (instr, instr_pc) holds stable.

  logic             inflight_q, inflight_d;
  logic             kill_q, kill_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW:0]      fifo_count;
  logic [PW+1:0]    credit_used;
  logic [EW-1:0]    fifo_head;
  logic             fifo_empty;
  logic             issue, push, pop;

  // Credit is taken against the registered count only: a pop this cycle does
  // not free a slot until the next cycle.
  assign credit_used = {1'b0, fifo_count} + {{(PW+1){1'b0}}, inflight_q};
  assign issue       = !rst && !redirect && (credit_used < (PW+2)'(DEPTH));

  assign imem_rd_en = issue;
  assign imem_addr  = pc;
  assign pc_stall   = !issue;

  assign push = inflight_q && !kill_q && !redirect;

  assign instr_valid = !fifo_empty;
  assign pop         = instr_valid && instr_ready && !redirect;
  assign instr_pc    = instr_valid ? fifo_head[EW-1:WIDTH] : '0;
  assign instr       = instr_valid ? fifo_head[WIDTH-1:0]  : '0;

  always_comb begin
    inflight_d = issue;
    kill_d     = redirect && inflight_q;
    pc_d       = issue ? pc : pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      pc_q       <= '0;
    end else begin
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      pc_q       <= pc_d;
    end
  end

  sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({pc_q, imem_rdata}),
    .count_o (fifo_count),
    .head_o  (fifo_head),
    .empty_o (fifo_empty)
  );

  // Credit rule guarantees the FIFO can never overflow; the PC register is
  // expected to present RESET_PC on the first cycle out of reset.
  logic rst_q;
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (!rst) begin
      assert (fifo_count <= (PW+1)'(DEPTH));
      assert (!(push && fifo_count == (PW+1)'(DEPTH) && !pop));
      if (rst_q) assert (pc == RESET_PC);
    end
  end
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: models the PC register and a 1-cycle imem that
// returns addr+0x100, and scoreboards every issued fetch against decode pops.
module tb_if_fetch_buffer;
  import if_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         redirect = 1'b0;
  logic         instr_ready = 1'b0;
  logic [W-1:0] pc = '0;
  logic [W-1:0] target = '0;
  logic [W-1:0] imem_rdata = '0;
  logic         pc_stall, imem_rd_en, instr_valid;
  logic [W-1:0] imem_addr, instr, instr_pc;

  always #5 clk = ~clk;

  if_fetch_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_stall    (pc_stall),
    .redirect    (redirect),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  int              checks_total = 0;
  int              checks_pass  = 0;
  logic [2*W-1:0]  exp_q[$];
  int              pops = 0;
  int              cyc = 0;
  logic [W-1:0]    last_pop_pc = '0;
  logic            hold_chk = 1'b0;
  logic [W-1:0]    hold_pc, hold_instr;
  logic            s_rd_en, s_stall;
  logic [W-1:0]    s_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks_total++;
    $display("FAIL %s: got timeout/unexpected event, required none", name);
  endtask

  // One clock cycle: sample and scoreboard mid-cycle, then advance the
  // PC-register and imem models after the edge.
  task automatic tick();
    fetch_entry_t e;
    #1;
    s_rd_en = imem_rd_en;
    s_addr  = imem_addr;
    s_stall = pc_stall;
    if (hold_chk) begin
      check("hold_valid", 64'(instr_valid), 64'(1));
      check("hold_pc", 64'(instr_pc), 64'(hold_pc));
      check("hold_instr", 64'(instr), 64'(hold_instr));
    end
    if (rst) begin
      exp_q.delete();
    end else begin
      if (redirect) exp_q.delete();
      else if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) fail_now("pop_without_issue");
        else begin
          e = exp_q.pop_front();
          check("pop_pc", 64'(instr_pc), 64'(e.pc));
          check("pop_instr", 64'(instr), 64'(e.instr));
          pops++;
          last_pop_pc = instr_pc;
        end
      end
      if (imem_rd_en) begin
        check("addr_eq_pc", 64'(imem_addr), 64'(pc));
        exp_q.push_back({imem_addr, imem_addr + 32'h100});
      end
    end
    hold_chk   = !rst && !redirect && instr_valid && !instr_ready;
    hold_pc    = instr_pc;
    hold_instr = instr;
    @(posedge clk);
    @(negedge clk);
    imem_rdata = s_rd_en ? s_addr + 32'h100 : (32'hDEAD_BEEF ^ 32'(cyc));
    pc = rst ? '0 : (redirect ? target : (s_stall ? pc : pc + 32'd4));
    cyc++;
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1;
    redirect = 1'b0;
    instr_ready = ready;
    tick();
    tick();
    #1;
    check("rst_rd_en", 64'(imem_rd_en), 64'(0));
    check("rst_stall", 64'(pc_stall), 64'(1));
    check("rst_valid", 64'(instr_valid), 64'(0));
    check("rst_instr", 64'(instr), 64'(0));
    check("rst_instr_pc", 64'(instr_pc), 64'(0));
    check("rst_count", 64'(dut.fifo_count), 64'(0));
    rst = 1'b0;
    cyc = 0;
  endtask

  typedef struct {
    logic         ready;
    logic         exp_rd_en;
    logic [W-1:0] exp_addr;
    logic         exp_stall;
    logic         exp_valid;
    int           exp_count;
    logic [W-1:0] exp_head;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int pops_start;
    bit found;

    // Fill with decode stalled, one pop while full, then issue resumes.
    tbl[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h04, 1'b0, 1'b0, 0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h08, 1'b0, 1'b1, 1, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 32'h0C, 1'b0, 1'b1, 2, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 3, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 4, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 4, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 4, 32'h0};
    tbl[8] = '{1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 3, 32'h4};

    // Streaming with decode always ready.
    do_reset(1'b1);
    #1;
    check("s_c0_rd_en", 64'(imem_rd_en), 64'(1));
    check("s_c0_addr", 64'(imem_addr), 64'(0));
    tick();
    #1;
    check("s_c1_valid", 64'(instr_valid), 64'(0));
    tick();
    #1;
    check("s_c2_valid", 64'(instr_valid), 64'(1));
    check("s_c2_pc", 64'(instr_pc), 64'(0));
    check("s_c2_instr", 64'(instr), 64'(32'h100));
    for (int i = 0; i < 8; i++) begin
      tick();
      #1;
      check("s_throughput_valid", 64'(instr_valid), 64'(1));
      check("s_throughput_pc", 64'(instr_pc), 64'(32'(4 * (i + 1))));
    end

    // Table-driven fill/full sequence.
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) begin
      instr_ready = tbl[i].ready;
      #1;
      check("t_rd_en", 64'(imem_rd_en), 64'(tbl[i].exp_rd_en));
      if (tbl[i].exp_rd_en) check("t_addr", 64'(imem_addr), 64'(tbl[i].exp_addr));
      check("t_stall", 64'(pc_stall), 64'(tbl[i].exp_stall));
      check("t_valid", 64'(instr_valid), 64'(tbl[i].exp_valid));
      check("t_count", 64'(dut.fifo_count), 64'(tbl[i].exp_count));
      if (tbl[i].exp_valid) check("t_head_pc", 64'(instr_pc), 64'(tbl[i].exp_head));
      tick();
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // Redirect the cycle after pc=0x20 issues.
    do_reset(1'b1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      #1;
      if (imem_rd_en && imem_addr == 32'h20) found = 1'b1;
      tick();
    end
    if (!found) fail_now("redir_find_0x20");
    redirect = 1'b1;
    target = 32'h80;
    #1;
    check("redir_no_issue", 64'(imem_rd_en), 64'(0));
    tick();
    redirect = 1'b0;
    #1;
    check("redir_valid_cleared", 64'(instr_valid), 64'(0));
    check("redir_count_cleared", 64'(dut.fifo_count), 64'(0));
    check("redir_issue_target", 64'(imem_addr), 64'(32'h80));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (instr_valid) found = 1'b1;
      else tick();
    end
    if (!found) fail_now("redir_first_valid");
    else begin
      check("redir_first_pc", 64'(instr_pc), 64'(32'h80));
      check("redir_first_instr", 64'(instr), 64'(32'h180));
    end
    for (int i = 0; i < 6; i++) tick();

    // Reset mid-operation with count=3 and a read in flight.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) tick();
    #1;
    check("mrst_pre_count", 64'(dut.fifo_count), 64'(3));
    check("mrst_pre_inflight", 64'(dut.inflight_q), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mrst_valid", 64'(instr_valid), 64'(0));
    check("mrst_count", 64'(dut.fifo_count), 64'(0));
    instr_ready = 1'b1;
    pops_start = pops;
    for (int i = 0; i < 10; i++) tick();
    check("mrst_pops_after", 64'(pops - pops_start > 0), 64'(1));

    // Wrap-around: 20 instructions with decode ready toggling.
    do_reset(1'b1);
    pops_start = pops;
    for (int i = 0; i < 200 && (pops - pops_start) < 20; i++) begin
      instr_ready = (i % 2 == 0);
      tick();
    end
    if (pops - pops_start < 20) fail_now("wrap_timeout");
    else check("wrap_last_pc", 64'(last_pop_pc), 64'(32'h4C));

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end
endmodule
